dcache_ctrl: RTL and testbench

- Non-blocking, direct-mapped, write-through data-cache controller between the LSQ and unified memory.
- Each cycle it takes one LSQ request and probes an external 32-line cache array (dcachemem) through rd1_idx/rd1_tag.
- On a load hit it answers combinationally; on a load miss it issues a BUS_LOAD and records the request in a FIFO miss buffer.
- Memory returns are matched by tag to fill the array and resolve the load-buffer entry; stores write memory and the array.

---
 rtl/dcache_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: non-blocking, direct-mapped, write-through data-cache controller.
// Probes an external 32-line array, forwards misses and stores to memory, and
// tracks outstanding load misses in a FIFO miss buffer matched by memory tag.
// Optional build macro: DCACHE_FILL_BYPASS_EN (a load miss that matches the fill
// completing this cycle is answered directly from the returning memory data).
module dcache_ctrl #(
  parameter int REQ_BUFF_SIZE = 16,
  parameter int REQ_BUFF_BITS = 4,
  parameter int LB_BITS       = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     nuke0,
  input  logic                     nuke1,
  input  logic                     lsq_req_valid,
  input  logic                     lsq_req_store,
  input  logic [63:0]              lsq_req_addr,
  input  logic [63:0]              lsq_req_data,
  input  logic                     lsq_req_thread,
  input  logic [LB_BITS-1:0]       lsq_req_lb_idx,
  input  logic [3:0]               Dmem2proc_response,
  input  logic [63:0]              Dmem2proc_data,
  input  logic [3:0]               Dmem2proc_tag,
  input  logic [63:0]              Dcache_data_1,
  input  logic                     Dcache_valid_1,
  output logic [1:0]               proc2Dmem_command,
  output logic [63:0]              proc2Dmem_addr,
  output logic [63:0]              proc2Dmem_data,
  output logic [63:0]              Dcache_data_out_1,
  output logic                     Dcache_valid_out_1,
  output logic                     Mem_request_failed,
  output logic [4:0]               rd1_idx,
  output logic [7:0]               rd1_tag,
  output logic                     wr1_req_en,
  output logic [4:0]               wr1_req_idx,
  output logic [7:0]               wr1_req_tag,
  output logic [63:0]              wr1_req_data,
  output logic                     wr1_missed_load_en,
  output logic [4:0]               wr1_missed_load_idx,
  output logic [7:0]               wr1_missed_load_tag,
  output logic                     lb_resp_valid,
  output logic                     lb_resp_thread,
  output logic [LB_BITS-1:0]       lb_resp_lb_idx,
  output logic [63:0]              lb_resp_data,
  output logic [REQ_BUFF_BITS-1:0] head_index,
  output logic [REQ_BUFF_BITS-1:0] tail_index,
  output logic [REQ_BUFF_BITS:0]   count,
  output logic                     full
);

  typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_cmd_e;

  // miss buffer payload (no reset needed, qualified by mb_valid)
  logic [3:0]               mb_mtag   [REQ_BUFF_SIZE];
  logic [4:0]               mb_idx    [REQ_BUFF_SIZE];
  logic [7:0]               mb_tag    [REQ_BUFF_SIZE];
  logic                     mb_thread [REQ_BUFF_SIZE];
  logic [LB_BITS-1:0]       mb_lb     [REQ_BUFF_SIZE];
  logic [REQ_BUFF_SIZE-1:0] mb_valid;
  logic [REQ_BUFF_SIZE-1:0] mb_squash;
  logic [REQ_BUFF_BITS-1:0] head, tail;
  logic [REQ_BUFF_BITS:0]   cnt;

  logic [4:0] req_idx;
  logic [7:0] req_tag;
  logic       req_live, is_load, is_store, accepted;
  logic       ret_match, head_squashed, bypass, miss, alloc, store_wr, buf_full;
  logic       unused_addr_lsb;

  function automatic logic [REQ_BUFF_BITS-1:0] ptr_inc(input logic [REQ_BUFF_BITS-1:0] p);
    return (p == REQ_BUFF_BITS'(REQ_BUFF_SIZE - 1)) ? '0 : p + REQ_BUFF_BITS'(1);
  endfunction

  assign unused_addr_lsb = ^lsq_req_addr[2:0];
  assign req_idx  = lsq_req_addr[7:3];
  assign req_tag  = lsq_req_addr[15:8];
  assign buf_full = (cnt == (REQ_BUFF_BITS+1)'(REQ_BUFF_SIZE));

  // request decode and memory-return matching; everything is idle during reset
  always_comb begin
    req_live      = reset && lsq_req_valid && !(lsq_req_thread ? nuke1 : nuke0);
    is_load       = req_live && !lsq_req_store;
    is_store      = req_live && lsq_req_store;
    accepted      = (Dmem2proc_response != 4'd0);
    ret_match     = reset && (Dmem2proc_tag != 4'd0) && mb_valid[head] &&
                    (Dmem2proc_tag == mb_mtag[head]);
    head_squashed = mb_squash[head] || (mb_thread[head] ? nuke1 : nuke0);
`ifdef DCACHE_FILL_BYPASS_EN
    bypass        = is_load && !Dcache_valid_1 && ret_match &&
                    (mb_idx[head] == req_idx) && (mb_tag[head] == req_tag);
`else
    bypass        = 1'b0;
`endif
    miss          = is_load && !Dcache_valid_1 && !bypass;
    alloc         = miss && !buf_full && accepted;
    store_wr      = is_store && accepted;
  end

  // output drive; a store write to the same line wins over the fill write
  always_comb begin
    proc2Dmem_command   = BUS_NONE;
    proc2Dmem_addr      = '0;
    proc2Dmem_data      = '0;
    Dcache_data_out_1   = '0;
    Dcache_valid_out_1  = 1'b0;
    Mem_request_failed  = 1'b0;
    rd1_idx             = '0;
    rd1_tag             = '0;
    wr1_req_en          = 1'b0;
    wr1_req_idx         = '0;
    wr1_req_tag         = '0;
    wr1_req_data        = '0;
    wr1_missed_load_en  = 1'b0;
    wr1_missed_load_idx = '0;
    wr1_missed_load_tag = '0;
    lb_resp_valid       = 1'b0;
    lb_resp_thread      = 1'b0;
    lb_resp_lb_idx      = '0;
    lb_resp_data        = '0;
    if (reset) begin
      rd1_idx = req_idx;
      rd1_tag = req_tag;
      if (is_load && Dcache_valid_1) begin
        Dcache_valid_out_1 = 1'b1;
        Dcache_data_out_1  = Dcache_data_1;
      end else if (bypass) begin
        Dcache_valid_out_1 = 1'b1;
        Dcache_data_out_1  = Dmem2proc_data;
      end else if (miss) begin
        if (buf_full) begin
          Mem_request_failed = 1'b1;
        end else begin
          proc2Dmem_command  = BUS_LOAD;
          proc2Dmem_addr     = {lsq_req_addr[63:3], 3'b000};
          Mem_request_failed = !accepted;
        end
      end else if (is_store) begin
        proc2Dmem_command  = BUS_STORE;
        proc2Dmem_addr     = {lsq_req_addr[63:3], 3'b000};
        proc2Dmem_data     = lsq_req_data;
        Mem_request_failed = !accepted;
      end
      if (store_wr) begin
        wr1_req_en   = 1'b1;
        wr1_req_idx  = req_idx;
        wr1_req_tag  = req_tag;
        wr1_req_data = lsq_req_data;
      end
      if (ret_match) begin
        wr1_missed_load_en  = !(store_wr && (req_idx == mb_idx[head]));
        wr1_missed_load_idx = mb_idx[head];
        wr1_missed_load_tag = mb_tag[head];
        if (!head_squashed) begin
          lb_resp_valid  = 1'b1;
          lb_resp_thread = mb_thread[head];
          lb_resp_lb_idx = mb_lb[head];
          lb_resp_data   = Dmem2proc_data;
        end
      end
    end
  end

  assign head_index = head;
  assign tail_index = tail;
  assign count      = cnt;
  assign full       = buf_full;

  // miss-buffer pointers, occupancy, valid and squash bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      mb_valid  <= '0;
      mb_squash <= '0;
    end else begin
      for (int unsigned i = 0; i < REQ_BUFF_SIZE; i++) begin
        if (mb_valid[i] && ((nuke0 && !mb_thread[i]) || (nuke1 && mb_thread[i])))
          mb_squash[i] <= 1'b1;
      end
      if (ret_match) begin
        mb_valid[head] <= 1'b0;
        head           <= ptr_inc(head);
      end
      if (alloc) begin
        mb_valid[tail]  <= 1'b1;
        mb_squash[tail] <= 1'b0;
        tail            <= ptr_inc(tail);
      end
      if (alloc && !ret_match)
        cnt <= cnt + 1'b1;
      else if (!alloc && ret_match)
        cnt <= cnt - 1'b1;
    end
  end

  // miss-buffer payload capture at the tail
  always_ff @(posedge clock) begin
    if (alloc) begin
      mb_mtag[tail]   <= Dmem2proc_response;
      mb_idx[tail]    <= req_idx;
      mb_tag[tail]    <= req_tag;
      mb_thread[tail] <= lsq_req_thread;
      mb_lb[tail]     <= lsq_req_lb_idx;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl. Accepted load misses are
// pushed to a scoreboard queue and popped when the matching memory tag returns.
module tb_dcache_ctrl;

  logic        clock, reset, nuke0, nuke1;
  logic        lsq_req_valid, lsq_req_store, lsq_req_thread;
  logic [63:0] lsq_req_addr, lsq_req_data;
  logic [2:0]  lsq_req_lb_idx;
  logic [3:0]  Dmem2proc_response, Dmem2proc_tag;
  logic [63:0] Dmem2proc_data, Dcache_data_1;
  logic        Dcache_valid_1;
  logic [1:0]  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr, proc2Dmem_data, Dcache_data_out_1;
  logic        Dcache_valid_out_1, Mem_request_failed;
  logic [4:0]  rd1_idx, wr1_req_idx, wr1_missed_load_idx;
  logic [7:0]  rd1_tag, wr1_req_tag, wr1_missed_load_tag;
  logic        wr1_req_en, wr1_missed_load_en;
  logic [63:0] wr1_req_data, lb_resp_data;
  logic        lb_resp_valid, lb_resp_thread;
  logic [2:0]  lb_resp_lb_idx;
  logic [3:0]  head_index, tail_index;
  logic [4:0]  count;
  logic        full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] mtag;
    logic       thr;
    logic [2:0] lb;
    logic [4:0] idx;
    logic [7:0] tag;
  } sb_t;
  sb_t sb[$];

  dcache_ctrl #(.REQ_BUFF_SIZE(16), .REQ_BUFF_BITS(4), .LB_BITS(3)) dut (
    .clock(clock), .reset(reset), .nuke0(nuke0), .nuke1(nuke1),
    .lsq_req_valid(lsq_req_valid), .lsq_req_store(lsq_req_store),
    .lsq_req_addr(lsq_req_addr), .lsq_req_data(lsq_req_data),
    .lsq_req_thread(lsq_req_thread), .lsq_req_lb_idx(lsq_req_lb_idx),
    .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
    .Dmem2proc_tag(Dmem2proc_tag), .Dcache_data_1(Dcache_data_1),
    .Dcache_valid_1(Dcache_valid_1), .proc2Dmem_command(proc2Dmem_command),
    .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_data(proc2Dmem_data),
    .Dcache_data_out_1(Dcache_data_out_1), .Dcache_valid_out_1(Dcache_valid_out_1),
    .Mem_request_failed(Mem_request_failed), .rd1_idx(rd1_idx), .rd1_tag(rd1_tag),
    .wr1_req_en(wr1_req_en), .wr1_req_idx(wr1_req_idx), .wr1_req_tag(wr1_req_tag),
    .wr1_req_data(wr1_req_data), .wr1_missed_load_en(wr1_missed_load_en),
    .wr1_missed_load_idx(wr1_missed_load_idx), .wr1_missed_load_tag(wr1_missed_load_tag),
    .lb_resp_valid(lb_resp_valid), .lb_resp_thread(lb_resp_thread),
    .lb_resp_lb_idx(lb_resp_lb_idx), .lb_resp_data(lb_resp_data),
    .head_index(head_index), .tail_index(tail_index), .count(count), .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    nuke0 = 0; nuke1 = 0;
    lsq_req_valid = 0; lsq_req_store = 0; lsq_req_addr = '0; lsq_req_data = '0;
    lsq_req_thread = 0; lsq_req_lb_idx = '0;
    Dmem2proc_response = '0; Dmem2proc_data = '0; Dmem2proc_tag = '0;
    Dcache_data_1 = '0; Dcache_valid_1 = 0;
  endtask

  task automatic drv_load(input logic [63:0] a, input logic thr, input logic [2:0] lb,
                          input logic [3:0] resp);
    lsq_req_valid = 1; lsq_req_store = 0; lsq_req_addr = a;
    lsq_req_thread = thr; lsq_req_lb_idx = lb; Dmem2proc_response = resp;
  endtask

  task automatic drv_store(input logic [63:0] a, input logic [63:0] d, input logic [3:0] resp);
    lsq_req_valid = 1; lsq_req_store = 1; lsq_req_addr = a; lsq_req_data = d;
    lsq_req_thread = 0; Dmem2proc_response = resp;
  endtask

  task automatic push(input logic [63:0] a, input logic thr, input logic [2:0] lb,
                      input logic [3:0] mtag);
    sb_t e;
    e.mtag = mtag; e.thr = thr; e.lb = lb; e.idx = a[7:3]; e.tag = a[15:8];
    sb.push_back(e);
  endtask

  // drive the return of the oldest outstanding miss and check the fill/response
  task automatic ret(input logic [63:0] d, input logic exp_fill, input logic exp_resp);
    sb_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    Dmem2proc_tag = e.mtag; Dmem2proc_data = d;
    #1;
    check("fill_en", 64'(wr1_missed_load_en), 64'(exp_fill));
    if (exp_fill) begin
      check("fill_idx", 64'(wr1_missed_load_idx), 64'(e.idx));
      check("fill_tag", 64'(wr1_missed_load_tag), 64'(e.tag));
    end
    check("lb_valid", 64'(lb_resp_valid), 64'(exp_resp));
    if (exp_resp) begin
      check("lb_data", lb_resp_data, d);
      check("lb_idx", 64'(lb_resp_lb_idx), 64'(e.lb));
      check("lb_thr", 64'(lb_resp_thread), 64'(e.thr));
    end
  endtask

  initial begin
    idle();
    reset = 0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_cmd", 64'(proc2Dmem_command), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    reset = 1;
    tick();

    // load miss 0x100, accepted with tag 3
    drv_load(64'h100, 0, 3'd2, 4'd3);
    #1;
    check("miss_cmd", 64'(proc2Dmem_command), 64'd1);
    check("miss_addr", proc2Dmem_addr, 64'h100);
    check("miss_fail", 64'(Mem_request_failed), 64'd0);
    check("rd1_idx", 64'(rd1_idx), 64'd0);
    check("rd1_tag", 64'(rd1_tag), 64'd1);
    push(64'h100, 0, 3'd2, 4'd3);
    tick(); idle();
    check("miss_count", 64'(count), 64'd1);
    check("miss_tail", 64'(tail_index), 64'd1);

    // load hit
    drv_load(64'h300, 0, 3'd1, 4'd0);
    Dcache_valid_1 = 1; Dcache_data_1 = 64'h55;
    #1;
    check("hit_valid", 64'(Dcache_valid_out_1), 64'd1);
    check("hit_data", Dcache_data_out_1, 64'h55);
    check("hit_cmd", 64'(proc2Dmem_command), 64'd0);
    tick(); idle();
    check("hit_count", 64'(count), 64'd1);

    // return tag 3 while a rejected load to the filling line is presented
    drv_load(64'h100, 0, 3'd4, 4'd0);
    ret(64'hDEAD, 1, 1);
`ifdef DCACHE_FILL_BYPASS_EN
    check("byp_valid", 64'(Dcache_valid_out_1), 64'd1);
    check("byp_data", Dcache_data_out_1, 64'hDEAD);
    check("byp_cmd", 64'(proc2Dmem_command), 64'd0);
`else
    check("nobyp_cmd", 64'(proc2Dmem_command), 64'd1);
    check("nobyp_fail", 64'(Mem_request_failed), 64'd1);
`endif
    tick(); idle();
    check("ret_count", 64'(count), 64'd0);

    // stores
    drv_store(64'h208, 64'd7, 4'd2);
    #1;
    check("st_cmd", 64'(proc2Dmem_command), 64'd2);
    check("st_addr", proc2Dmem_addr, 64'h208);
    check("st_data", proc2Dmem_data, 64'd7);
    check("st_wen", 64'(wr1_req_en), 64'd1);
    check("st_widx", 64'(wr1_req_idx), 64'd1);
    check("st_wtag", 64'(wr1_req_tag), 64'd2);
    check("st_wdata", wr1_req_data, 64'd7);
    check("st_fail", 64'(Mem_request_failed), 64'd0);
    Dmem2proc_response = 4'd0;
    #1;
    check("st_rej_fail", 64'(Mem_request_failed), 64'd1);
    check("st_rej_wen", 64'(wr1_req_en), 64'd0);
    tick(); idle();
    check("st_count", 64'(count), 64'd0);

    // rejected load miss
    drv_load(64'h480, 1, 3'd0, 4'd0);
    #1;
    check("rej_fail", 64'(Mem_request_failed), 64'd1);
    tick(); idle();
    check("rej_count", 64'(count), 64'd0);

    // fill the buffer
    for (int i = 0; i < 16; i++) begin
      logic [63:0] a;
      a = {48'h0, 8'(i + 16), 5'(i), 3'b000};
      drv_load(a, i[0], i[2:0], 4'((i % 15) + 1));
      #1;
      check("fill_cmd", 64'(proc2Dmem_command), 64'd1);
      push(a, i[0], i[2:0], 4'((i % 15) + 1));
      tick(); idle();
    end
    check("full_flag", 64'(full), 64'd1);
    check("full_count", 64'(count), 64'd16);
    drv_load(64'hA000, 0, 3'd0, 4'd5);
    #1;
    check("full_cmd", 64'(proc2Dmem_command), 64'd0);
    check("full_fail", 64'(Mem_request_failed), 64'd1);
    tick(); idle();
    check("full_count2", 64'(count), 64'd16);

    // pop while full: allocation still rejected
    drv_load(64'hA000, 0, 3'd0, 4'd5);
    ret(64'hD000_0000, 1, 1);
    check("popfull_fail", 64'(Mem_request_failed), 64'd1);
    tick(); idle();
    check("popfull_count", 64'(count), 64'd15);

    // pop plus allocation: count unchanged
    drv_load(64'hB018, 1, 3'd6, 4'd6);
    ret(64'hD000_0001, 1, 1);
    check("popalloc_cmd", 64'(proc2Dmem_command), 64'd1);
    push(64'hB018, 1, 3'd6, 4'd6);
    tick(); idle();
    check("popalloc_count", 64'(count), 64'd15);

    for (int n = 2; sb.size() > 0; n++) begin
      ret(64'hD000_0000 + 64'(n), 1, 1);
      tick(); idle();
    end
    check("drain_count", 64'(count), 64'd0);

    // fill and store to the same index in one cycle: store wins
    drv_load(64'h0528, 0, 3'd5, 4'd9);
    #1;
    push(64'h0528, 0, 3'd5, 4'd9);
    tick(); idle();
    drv_store(64'h0728, 64'h77, 4'd2);
    ret(64'hC0DE, 0, 1);
    check("coll_wen", 64'(wr1_req_en), 64'd1);
    check("coll_widx", 64'(wr1_req_idx), 64'd5);
    tick(); idle();
    check("coll_count", 64'(count), 64'd0);

    // thread-1 miss squashed by nuke1
    drv_load(64'h0340, 1, 3'd3, 4'd4);
    #1;
    push(64'h0340, 1, 3'd3, 4'd4);
    tick(); idle();
    nuke1 = 1;
    tick(); idle();
    ret(64'hBEEF, 1, 0);
    tick(); idle();
    check("nuke_count", 64'(count), 64'd0);

    // request from a thread nuked this cycle
    drv_load(64'h0640, 0, 3'd1, 4'd7);
    nuke0 = 1;
    #1;
    check("nreq_cmd", 64'(proc2Dmem_command), 64'd0);
    check("nreq_fail", 64'(Mem_request_failed), 64'd0);
    tick(); idle();
    check("nreq_count", 64'(count), 64'd0);

    // asynchronous reset with three outstanding misses
    for (int i = 1; i <= 3; i++) begin
      drv_load(64'(i * 256), 0, 3'(i), 4'(i));
      tick(); idle();
    end
    check("pre_rst_count", 64'(count), 64'd3);
    drv_load(64'h900, 0, 3'd0, 4'd1);
    reset = 0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_head", 64'(head_index), 64'd0);
    check("arst_tail", 64'(tail_index), 64'd0);
    check("arst_cmd", 64'(proc2Dmem_command), 64'd0);
    idle();
    tick();
    reset = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
